// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed little-endian byte stream and writes
// it as 32-bit words into instruction memory starting at BASE_ADDR. The core
// is held in reset until a load completes successfully.
//
// Optional feature: define LOADER_CHECKSUM_EN to append a one-byte XOR
// checksum after the data. A mismatched checksum aborts the load.
//
// Handshakes:
//   byte stream  - a byte transfers on a rising edge where in_valid && in_ready.
//                  in_ready depends only on the current state.
//   memory write - mem_we/mem_addr/mem_wdata are held stable while mem_we is high
//                  and complete on the rising edge where mem_ready is high.
//                  mem_ready may be asserted combinationally during that cycle.
module prog_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h2000,
  parameter int unsigned MAX_WORDS = 129024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd6;
`endif

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_count_q, word_count_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] word_count_inc;

  // Byte lane selection shared by the header and data assembly.
  always_comb begin
    lane_shift     = {byte_idx_q, 3'b000};
    lane_mask      = ~(32'h0000_00FF << lane_shift);
    lane_data      = {24'd0, in_data} << lane_shift;
    word_count_inc = word_count_q + 32'd1;
  end

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    len_d        = len_q;
    word_d       = word_q;
    word_count_d = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_HDR;
          byte_idx_d   = 2'd0;
          word_count_d = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
          len_d      = (len_q & lane_mask) | lane_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Zero length is an empty but valid program.
            if (len_d == 32'd0)            state_d = S_DONE;
            else if (len_d > MAX_WORDS_W)  state_d = S_ERR;
            else                           state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = (word_q & lane_mask) | lane_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          word_count_d = word_count_inc;
          if (word_count_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_HDR;
          byte_idx_d   = 2'd0;
          word_count_d = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      len_q        <= 32'd0;
      word_q       <= 32'd0;
      word_count_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      len_q        <= len_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Outputs decoded from state; the write address tracks words written.
  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    in_ready = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    accept     = in_valid && in_ready;
    mem_we     = (state_q == S_WRITE);
    mem_addr   = BASE_ADDR + ({32'd0, word_count_q} << 2);
    mem_wdata  = word_q;
    core_hold  = (state_q != S_DONE);
    done       = (state_q == S_DONE);
    error      = (state_q == S_ERR);
    word_count = word_count_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Writes are checked against an expected
// queue of {addr, data}; all comparisons go through check().
module tb_prog_loader;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [31:0] word_count;
  logic [2:0]  dbg_state;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int we_cycles = 0;
  logic [95:0] exp_q[$];
  logic [63:0] exp_addr;
  logic [7:0]  csum_acc;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: samples just after the falling edge; a write is taken on
  // the following rising edge when mem_we && mem_ready.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (mem_we) we_cycles++;
      if (mem_we && mem_ready) begin
        wr_count++;
        if (exp_q.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 96'd0);
        else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // Drivers: all called at a falling edge, return at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 64'h2000;
    csum_acc = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 96'd0, 96'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] l);
    for (int k = 0; k < 4; k++) send_byte(l[8*k +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 64'd4;
    for (int k = 0; k < 4; k++) begin
      csum_acc = csum_acc ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_acc);
`else
    @(negedge clk);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {95'd0, in_ready},  96'd0);
    check({tag, "_mem_we"},    {95'd0, mem_we},    96'd0);
    check({tag, "_mem_addr"},  {32'd0, mem_addr},  96'h2000);
    check({tag, "_mem_wdata"}, {64'd0, mem_wdata}, 96'd0);
    check({tag, "_core_hold"}, {95'd0, core_hold}, 96'd1);
    check({tag, "_done"},      {95'd0, done},      96'd0);
    check({tag, "_error"},     {95'd0, error},     96'd0);
    check({tag, "_count"},     {64'd0, word_count}, 96'd0);
  endtask

  int we_snap;
  int wr_snap;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; mem_ready = 1'b1;
    exp_addr = 64'h2000; csum_acc = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", {93'd0, dbg_state}, {93'd0, ST_IDLE});

    // Single word load.
    pulse_start();
    send_hdr(32'd1);
    send_word(32'hC800_0013);
    finish_load();
    check("w1_done",      {95'd0, done},       96'd1);
    check("w1_core_hold", {95'd0, core_hold},  96'd0);
    check("w1_count",     {64'd0, word_count}, 96'd1);
    check("w1_writes",    wr_count,            96'd1);

    // Two words, first write back-pressured for 3 cycles.
    pulse_start();
    check("restart_done",  {95'd0, done},       96'd0);
    check("restart_hold",  {95'd0, core_hold},  96'd1);
    check("restart_count", {64'd0, word_count}, 96'd0);
    send_hdr(32'd2);
    mem_ready = 1'b0;
    send_word(32'h4433_2211);
    for (int c = 0; c < 3; c++) begin
      check("stall_we",   {95'd0, mem_we},    96'd1);
      check("stall_addr", {32'd0, mem_addr},  96'h2000);
      check("stall_data", {64'd0, mem_wdata}, 96'h4433_2211);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    check("stall_last_we",   {95'd0, mem_we},    96'd1);
    check("stall_last_data", {64'd0, mem_wdata}, 96'h4433_2211);
    @(negedge clk);
    check("after_stall_we",    {95'd0, mem_we},     96'd0);
    check("after_stall_count", {64'd0, word_count}, 96'd1);
    send_word(32'hDDCC_BBAA);
    finish_load();
    check("w2_done",   {95'd0, done},       96'd1);
    check("w2_count",  {64'd0, word_count}, 96'd2);
    check("w2_writes", wr_count,            96'd3);

    // Zero length: done right after the header, no writes.
    wr_snap = wr_count;
    pulse_start();
    send_hdr(32'd0);
    check("zero_done",   {95'd0, done}, 96'd1);
    check("zero_writes", wr_count - wr_snap, 96'd0);

    // One above the limit aborts.
    we_snap = we_cycles;
    pulse_start();
    send_hdr(32'd129025);
    check("over_error", {95'd0, error}, 96'd1);
    check("over_done",  {95'd0, done},  96'd0);

    // All-ones header aborts and never writes.
    pulse_start();
    check("err_restart_error", {95'd0, error}, 96'd0);
    send_hdr(32'hFFFF_FFFF);
    @(negedge clk);
    check("ff_error",    {95'd0, error},     96'd1);
    check("ff_hold",     {95'd0, core_hold}, 96'd1);
    check("ff_in_ready", {95'd0, in_ready},  96'd0);
    check("ff_no_we",    we_cycles - we_snap, 96'd0);

    // Exactly the limit is accepted; start mid-load is ignored; reset mid-word.
    pulse_start();
    send_hdr(32'd129024);
    check("max_error", {95'd0, error},    96'd0);
    check("max_ready", {95'd0, in_ready}, 96'd1);
    send_byte(8'h5A);
    pulse_start();
    check("start_ignored", {93'd0, dbg_state}, {93'd0, ST_DATA});
    send_byte(8'hA5);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;

    // Bytes offered while idle are not consumed.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    check("idle_no_consume", {93'd0, dbg_state}, {93'd0, ST_IDLE});
    in_valid = 1'b0;
    pulse_start();
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF);
    finish_load();
    check("recover_done",  {95'd0, done},       96'd1);
    check("recover_count", {64'd0, word_count}, 96'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum of 11^22^33^44 = 44.
    pulse_start();
    send_hdr(32'd1);
    send_word(32'h4433_2211);
    send_byte(8'h44);
    check("csum_ok_done", {95'd0, done}, 96'd1);
    pulse_start();
    send_hdr(32'd1);
    send_word(32'h4433_2211);
    send_byte(8'h45);
    check("csum_bad_error", {95'd0, error}, 96'd1);
    check("csum_bad_done",  {95'd0, done},  96'd0);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
